reg_block_mover: RTL and testbench
==================================

Name: reg_block_mover

Overview:
- Sequential initiator that drives the read and write ports of the 32-bit register file to copy a block of registers from one index range to another, one word per cycle.
- Sits beside the datapath.
- The control unit pulses `start` with source, destination and length, then waits for `done`.
- Overlapping ranges are handled so the copy is non-destructive, with memmove semantics.

Parameters:
WordLen, 32, register word width in bits.
AddrBits, 14, register index width; the register file holds 2**AddrBits words.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
src_base  input  AddrBits  first source register index.
dst_base  input  AddrBits  first destination register index.
len  input  AddrBits+1  number of words to move (0..2**AddrBits).
rf_read_addr  output  AddrBits  drives the register file read-address port.
rf_read_data  input  WordLen  combinational read data returned for rf_read_addr.
rf_write_en  output  1  register file write enable.
rf_write_addr  output  AddrBits  register file write index.
rf_write_data  output  WordLen  register file write data.
busy  output  1  high while a transfer is in progress.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - busy, done, rf_write_en = 0.
  - rf_read_addr, rf_write_addr, rf_write_data = 0.
  - Takes effect immediately, including mid-transfer. A partially moved block stays partially moved, and no further writes occur.
- States: IDLE, MOVE, FIN.
- IDLE:
  - When start=1 at posedge k, latch src_base, dst_base, len; clear the word counter.
  - Compute direction: diff = (dst_base - src_base) mod 2**AddrBits.
    - DESCENDING if diff != 0 and diff < len.
    - Otherwise ASCENDING.
  - Go to MOVE if len != 0; go to FIN if len == 0.
- MOVE, one word per cycle, for cycles k+1 .. k+len:
  - ASCENDING, word i: rf_read_addr = src+i, rf_write_addr = dst+i.
  - DESCENDING, word i: rf_read_addr = src+len-1-i, rf_write_addr = dst+len-1-i.
  - rf_write_data = rf_read_data (combinational pass-through, same cycle). The write commits at the next posedge.
  - All index arithmetic is modulo 2**AddrBits; ranges wrap past the top index to 0.
  - rf_write_en = 1, except when rf_write_addr == 0: register 0 is hardwired zero, so that write is suppressed with rf_write_en = 0, but the word is still counted.
  - After the len-th word, go to FIN.
- FIN:
  - done=1 for exactly one cycle (cycle k+len+1, or k+1 when len=0), then return to IDLE.
  - start may be accepted on the edge that ends FIN's cycle only if state is IDLE, so a new start is accepted at the earliest in cycle k+len+2.
- busy = 1 in MOVE and FIN, 0 in IDLE.
- start while busy: ignored, no queuing.
- len = 2**AddrBits moves the whole file. Counter width is AddrBits+1, so there is no overflow.
- len > 2**AddrBits cannot be encoded.
- dst == src: runs ASCENDING, rewriting the same values, with identical timing.
- rf_read_addr, rf_write_addr, rf_write_data hold their last value in IDLE/FIN. rf_write_en is 0 outside MOVE.

Optional Feature:
Macro REG_MOVER_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` [WordLen-1:0], cleared to 0 on reset and on each accepted start.
  - XOR-accumulates every rf_read_data word read in MOVE, including words whose write was suppressed.
  - Stable and valid from the done cycle until the next accepted start.
- Not defined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic ascending:
  - Stimulus: preload R10..R13 = 0xA0..0xA3; start src=10 dst=20 len=4.
  - Response: writes to 20,21,22,23 in cycles k+1..k+4; done in k+5; R20..R23 = 0xA0..0xA3; R10..R13 unchanged.
- Overlap forward (DESCENDING):
  - Stimulus: R5..R8 = 1,2,3,4; start src=5 dst=7 len=4.
  - Response: write order 10,9,8,7; final R7..R10 = 1,2,3,4; R5=1, R6=2.
- Overlap backward:
  - Stimulus: R7..R10 = 1,2,3,4; src=7 dst=5 len=4.
  - Response: ascending order 5,6,7,8; final R5..R8 = 1,2,3,4.
- Zero and wrap:
  - Stimulus: len=0.
  - Response: no rf_write_en; done at k+1.
  - Stimulus: src=1 dst=2**AddrBits-2 len=3.
  - Response: writes to 2**AddrBits-2 and 2**AddrBits-1; write to index 0 suppressed; done at k+4.
- Busy and reset:
  - Stimulus: start ignored while busy=1.
  - Response: no effect on the running transfer.
  - Stimulus: rst_n low after word 2 of len=8.
  - Response: rf_write_en drops immediately, no done pulse, only 2 words written; next start runs normally.
- Checksum (REG_MOVER_CHECKSUM_EN):
  - Stimulus: source words 0x1, 0x2, 0x4.
  - Response: checksum = 0x7 at done.
  - Stimulus: a new start.
  - Response: checksum clears to 0.

Source files
------------

// File: rtl/reg_block_mover_if.sv
// reg_block_mover_if: start/length request, register-file read/write ports and status for the block mover.
// master = the mover itself, slave = the control unit / register file side.
// Build option REG_MOVER_CHECKSUM_EN adds the checksum signal.
interface reg_block_mover_if #(
  parameter int WordLen  = 32,
  parameter int AddrBits = 14
);
  logic                start;
  logic [AddrBits-1:0] src_base;
  logic [AddrBits-1:0] dst_base;
  logic [AddrBits:0]   len;
  logic [AddrBits-1:0] rf_read_addr;
  logic [WordLen-1:0]  rf_read_data;
  logic                rf_write_en;
  logic [AddrBits-1:0] rf_write_addr;
  logic [WordLen-1:0]  rf_write_data;
  logic                busy;
  logic                done;
`ifdef REG_MOVER_CHECKSUM_EN
  logic [WordLen-1:0]  checksum;
`endif

  modport master (
    input  start, src_base, dst_base, len, rf_read_data,
    output rf_read_addr, rf_write_en, rf_write_addr, rf_write_data, busy, done
`ifdef REG_MOVER_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output start, src_base, dst_base, len, rf_read_data,
    input  rf_read_addr, rf_write_en, rf_write_addr, rf_write_data, busy, done
`ifdef REG_MOVER_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/reg_block_mover.sv
// reg_block_mover: copies len register-file words src->dst with memmove semantics, one word per cycle.
// Latency: done pulses len+1 cycles after the accepting edge (1 cycle for len=0); start while busy is ignored.
// Build option REG_MOVER_CHECKSUM_EN adds an XOR checksum of every word read during the move.
module reg_block_mover #(
  parameter int WordLen  = 32,
  parameter int AddrBits = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_block_mover_if.master bus
);

  typedef enum logic [1:0] {IDLE, MOVE, FIN} state_e;

  state_e              state_q, state_d;
  logic [AddrBits-1:0] rd_addr_q, rd_addr_d;
  logic [AddrBits-1:0] wr_addr_q, wr_addr_d;
  logic [AddrBits:0]   len_q, len_d;
  logic [AddrBits:0]   cnt_q, cnt_d;
  logic                desc_q, desc_d;
  logic [WordLen-1:0]  wdata_q, wdata_d;
`ifdef REG_MOVER_CHECKSUM_EN
  logic [WordLen-1:0]  csum_q, csum_d;
`endif

  // Direction decision: a forward overlap (destination lands inside the
  // source range) must be copied top-down so sources are read before being
  // overwritten. dst == src gives diff == 0 and runs ascending.
  logic [AddrBits-1:0] diff;
  logic                start_desc;
  logic [AddrBits:0]   len_m1;
  logic [AddrBits-1:0] first_off;
  logic [AddrBits-1:0] step;
  logic                last_word;

  assign diff       = bus.dst_base - bus.src_base;
  assign start_desc = (diff != '0) && ({1'b0, diff} < bus.len);
  assign len_m1     = bus.len - (AddrBits+1)'(1);
  assign first_off  = start_desc ? len_m1[AddrBits-1:0] : '0;
  assign step       = desc_q ? '1 : AddrBits'(1);
  assign last_word  = (cnt_q == (len_q - (AddrBits+1)'(1)));

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      desc_q    <= 1'b0;
      wdata_q   <= '0;
`ifdef REG_MOVER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      desc_q    <= desc_d;
      wdata_q   <= wdata_d;
`ifdef REG_MOVER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, step one word per MOVE cycle, one FIN cycle.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    desc_d    = desc_q;
    wdata_d   = wdata_q;
`ifdef REG_MOVER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d  = bus.len;
          cnt_d  = '0;
          desc_d = start_desc;
`ifdef REG_MOVER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (bus.len != '0) begin
            state_d   = MOVE;
            rd_addr_d = bus.src_base + first_off;
            wr_addr_d = bus.dst_base + first_off;
          end else begin
            // Empty move: addresses keep their previous values.
            state_d = FIN;
          end
        end
      end
      MOVE: begin
        wdata_d = bus.rf_read_data;
`ifdef REG_MOVER_CHECKSUM_EN
        csum_d  = csum_q ^ bus.rf_read_data;
`endif
        cnt_d   = cnt_q + (AddrBits+1)'(1);
        if (last_word) begin
          // Addresses stay on the last word moved.
          state_d = FIN;
        end else begin
          rd_addr_d = rd_addr_q + step;
          wr_addr_d = wr_addr_q + step;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register 0 is hardwired zero, so its write is dropped but still counted.
  assign bus.rf_read_addr  = rd_addr_q;
  assign bus.rf_write_addr = wr_addr_q;
  assign bus.rf_write_en   = (state_q == MOVE) && (wr_addr_q != '0);
  assign bus.rf_write_data = (state_q == MOVE) ? bus.rf_read_data : wdata_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == FIN);
`ifdef REG_MOVER_CHECKSUM_EN
  assign bus.checksum      = csum_q;
`endif

endmodule

// File: tb/tb_reg_block_mover.sv
// Testbench for reg_block_mover: register file model plus memmove reference model.
// Directed cases (ascending, both overlaps, len=0, wrap, busy start, mid-move reset, full file) and random moves.
module tb_reg_block_mover;
  localparam int AW = 14;
  localparam int WL = 32;
  localparam int N  = 1 << AW;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_block_mover_if #(.WordLen(WL), .AddrBits(AW)) bus ();
  reg_block_mover #(.WordLen(WL), .AddrBits(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0]   mem     [N];
  logic [31:0]   ref_mem [N];
  wr_t           log_q[$];
  wr_t           exp_q[$];
  int            cyc = 0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_dat = '0;
  int            vectors = 0;
  int            errors  = 0;

  assign bus.rf_read_data = mem[bus.rf_read_addr];

  // Register file: backdoor preload port plus the mover's write port; logs every committed write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (bus.rf_write_en) begin
      mem[bus.rf_write_addr] <= bus.rf_write_data;
      log_q.push_back('{int'(bus.rf_write_addr), bus.rf_write_data, cyc});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = AW'(a);
    pl_dat  = (a == 0) ? 32'h0 : d;
    ref_mem[a] = pl_dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic cmp_mem(input string nm);
    int d = 0;
    for (int a = 0; a < N; a++) if (mem[a] !== ref_mem[a]) d++;
    chk({nm, "_memdiff"}, d, 0);
  endtask

  // One complete move; called at a negedge with the mover idle.
  task automatic run_move(input int src, input int dst, input int len, input bit noise, input string nm);
    int          diff, c0, n, off, a, m;
    bit          desc;
    logic [31:0] tmp[$];
    logic [31:0] x;
    c0   = cyc;
    diff = (dst - src) & (N - 1);
    desc = (diff != 0) && (diff < len);
    tmp.delete();
    x = 32'h0;
    for (int i = 0; i < len; i++) begin
      tmp.push_back(ref_mem[(src + i) % N]);
      x ^= ref_mem[(src + i) % N];
    end
    exp_q.delete();
    for (int j = 0; j < len; j++) begin
      off = desc ? (len - 1 - j) : j;
      a   = (dst + off) % N;
      if (a != 0) exp_q.push_back('{a, tmp[off], c0 + 1 + j});
    end
    for (int i = 0; i < len; i++) begin
      a = (dst + i) % N;
      if (a != 0) ref_mem[a] = tmp[i];
    end
    log_q.delete();
    bus.start    = 1'b1;
    bus.src_base = AW'(src);
    bus.dst_base = AW'(dst);
    bus.len      = (AW+1)'(len);
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_busy"}, bus.busy, 1);
`ifdef REG_MOVER_CHECKSUM_EN
    chk({nm, "_csum_clr"}, bus.checksum, 0);
`endif
    n = 0;
    while (!bus.done && n < len + 4) begin
      if (noise) begin
        bus.start    = 1'b1;
        bus.src_base = AW'($urandom);
        bus.dst_base = AW'($urandom);
        bus.len      = (AW+1)'($urandom_range(1, 20));
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk({nm, "_done_cyc"}, cyc, c0 + len + 1);
    chk({nm, "_done"}, bus.done, 1);
`ifdef REG_MOVER_CHECKSUM_EN
    chk({nm, "_csum"}, bus.checksum, x);
`endif
    @(negedge clk);
    chk({nm, "_done_drop"}, bus.done, 0);
    chk({nm, "_idle"}, bus.busy, 0);
    chk({nm, "_nwr"}, log_q.size(), exp_q.size());
    m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk({nm, "_wr_addr"}, log_q[i].addr, exp_q[i].addr);
      chk({nm, "_wr_data"}, log_q[i].data, exp_q[i].data);
      chk({nm, "_wr_cyc"},  log_q[i].cyc,  exp_q[i].cyc);
    end
    cmp_mem(nm);
  endtask

  initial begin
    int s, d, l;
    bus.start = 1'b0; bus.src_base = '0; bus.dst_base = '0; bus.len = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_we",    bus.rf_write_en, 0);
    chk("rst_raddr", bus.rf_read_addr, 0);
    chk("rst_waddr", bus.rf_write_addr, 0);
    chk("rst_wdata", bus.rf_write_data, 0);
`ifdef REG_MOVER_CHECKSUM_EN
    chk("rst_csum",  bus.checksum, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < N; a++) poke(a, $urandom);

    for (int i = 0; i < 4; i++) poke(10 + i, 32'hA0 + i);
    run_move(10, 20, 4, 1'b0, "asc");
    chk("asc_r20", mem[20], 32'hA0);
    chk("asc_r23", mem[23], 32'hA3);
    chk("asc_r10", mem[10], 32'hA0);

    for (int i = 0; i < 4; i++) poke(5 + i, i + 1);
    run_move(5, 7, 4, 1'b0, "fwd");
    chk("fwd_r10", mem[10], 4);
    chk("fwd_r6",  mem[6], 2);

    for (int i = 0; i < 4; i++) poke(7 + i, i + 1);
    run_move(7, 5, 4, 1'b0, "bwd");
    chk("bwd_r8", mem[8], 4);

    run_move(3, 9, 0, 1'b0, "len0");
    run_move(1, N - 2, 3, 1'b0, "wrap");
    chk("wrap_r0", mem[0], 0);
    run_move(200, 210, 12, 1'b1, "busy");

    poke(40, 32'h1); poke(41, 32'h2); poke(42, 32'h4);
    run_move(40, 50, 3, 1'b0, "csum");

    // Reset after two words of an 8-word move.
    ref_mem[300] = ref_mem[100];
    ref_mem[301] = ref_mem[101];
    log_q.delete();
    bus.start = 1'b1; bus.src_base = AW'(100); bus.dst_base = AW'(300); bus.len = (AW+1)'(8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_we",    bus.rf_write_en, 0);
    chk("mrst_busy",  bus.busy, 0);
    chk("mrst_done",  bus.done, 0);
    chk("mrst_waddr", bus.rf_write_addr, 0);
    chk("mrst_nwr",   log_q.size(), 2);
    @(negedge clk);
    chk("mrst_done2", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle", bus.busy, 0);
    cmp_mem("mrst");
    run_move(100, 300, 8, 1'b0, "after_rst");

    for (int t = 0; t < 14; t++) begin
      s = $urandom_range(0, N - 1);
      l = $urandom_range(0, 40);
      d = (t % 2 == 0) ? ((s + $urandom_range(0, 45)) % N) : $urandom_range(0, N - 1);
      if (t % 4 == 1) d = (s + N - $urandom_range(1, 40)) % N;
      run_move(s, d, l, t[0], "rnd");
    end

    s = $urandom_range(0, N - 1);
    run_move(s, s, N, 1'b0, "full");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
